micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have one parameter: FETCH_ADDR, default 10'd0, the control-store address of the fetch routine.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 uword  input  26  current microword read from the control store at uaddr: [25:21] source, [20:16] ALU op, [15:13] next-select, [12:10] cond, [9:0] branch target.
REQ-005 opcode  input  8  IR contents, valid whenever next-select is 111.
REQ-006 z_flag, n_flag  input  1 each  datapath zero and negative flags, sampled on the edge that retires the current microword.
REQ-007 stall  input  1  holds all sequencer state when high.
REQ-008 uaddr  output  10  registered control-store address.
REQ-009 wide_active  output  1  WIDE prefix pending.
REQ-010 dispatch  output  1  one-cycle pulse registered on each map dispatch.
REQ-011 illegal  output  1  sticky flag for an unmapped opcode.

Function
REQ-012 The block SHALL issue one microword per unstalled cycle; the next uaddr SHALL be registered one edge after uword is presented (zero-bubble sequencing).
REQ-013 The next-select field SHALL control the next uaddr as follows:
- 000: uaddr+1.
- 001: conditional; the cond field selects the test.
- 010: branch target.
- 110: FETCH_ADDR.
- 111: map dispatch.
- 011, 100 and 101: uaddr+1.
REQ-014 The cond field SHALL select: 000 = z_flag, 001 = n_flag, 010 = always true, all other values = false; if the test is true, next = branch target, else uaddr+1.
REQ-015 uaddr+1 SHALL wrap from 1023 to 0 with no flag.
REQ-016 Next-select 110 with cond 111 SHALL set wide_active and go to FETCH_ADDR.
REQ-017 The map SHALL give the following normal/wide addresses:
- 0x60 -> 4; 0x64 -> 13; 0x7E -> 22; 0xB0 -> 31; 0xA7 -> 40.
- 0x99 -> 44; 0x9B -> 51; 0x9F -> 58.
- 0x00 -> 68; 0x57 -> 69; 0x59 -> 70; 0x5F -> 141.
- 0xC4 -> 152; 0x13 -> 153; 0xB6 -> 181; 0xAC -> 218.
- ILOAD 0x15 -> 86 / wide 75.
- ISTORE 0x36 -> 108 / wide 97.
- BIPUSH 0x10 -> 130 / wide 119.
- IINC 0x84 -> 165 / wide 240.
REQ-018 On dispatch, the wide address SHALL be used when wide_active=1 and the opcode has a wide entry; otherwise the normal address SHALL be used.
REQ-019 Every dispatch SHALL clear wide_active, including dispatch of 0xC4 and of opcodes with no wide entry.
REQ-020 An unmapped opcode at dispatch SHALL:
- set next uaddr to FETCH_ADDR;
- set illegal;
- clear wide_active.
REQ-021 illegal SHALL stay set until reset.
REQ-022 dispatch SHALL be 1 for exactly the cycle after a dispatch edge, mapped or unmapped, and 0 otherwise.
REQ-023 With stall=1, the block SHALL hold uaddr, wide_active and illegal, drive dispatch to 0, and ignore uword, opcode and the flags.
REQ-024 Flags SHALL be consumed only when next-select is 001; X on the flags under any other select SHALL not propagate.

Reset
REQ-025 With reset=1 at an edge, the block SHALL set uaddr=FETCH_ADDR, wide_active=0, dispatch=0 and illegal=0, regardless of stall.
REQ-026 Reset asserted mid-routine (e.g. uaddr=190) SHALL abandon the routine and any pending WIDE state at that edge.
REQ-027 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-028 Reset then fetch words {next-select 000 ×3, then 111} with opcode 0x60 -> uaddr 0,1,2,3,4, and dispatch=1 only in the cycle uaddr=4.
REQ-029 Conditional branch with uaddr=10, next-select 001, cond 000, target 0x100 -> uaddr 256 when z_flag=1 and 11 when z_flag=0; repeat with cond 001 on n_flag.
REQ-030 WIDE sequence: the word at 152 (next-select 110, cond 111) -> uaddr 0 and wide_active=1; the next dispatch of 0x15 -> 75 and wide_active=0; a further dispatch of 0x15 -> 86.
REQ-031 WIDE then dispatch of 0x60 -> 4 and wide_active=0.
REQ-032 Dispatch of opcode 0xFF -> uaddr 0, illegal=1, dispatch pulse; illegal stays 1 through later normal dispatches until reset.
REQ-033 Stall asserted 3 cycles at uaddr=50 with next-select 000 -> uaddr stays 50 and dispatch stays 0, then 51 on release.
REQ-034 Wrap: uaddr=1023 with next-select 000 -> 0.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: picks the next control-store address each cycle from
// the microword's next-select field, with conditional branches, WIDE prefix and opcode dispatch.
module micro_sequencer #(
   parameter logic [9:0] FETCH_ADDR = 10'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [25:0] uword,
   input  logic [7:0]  opcode,
   input  logic        z_flag,
   input  logic        n_flag,
   input  logic        stall,
   output logic [9:0]  uaddr,
   output logic        wide_active,
   output logic        dispatch,
   output logic        illegal
);

   localparam logic [2:0] SEL_INC  = 3'b000;
   localparam logic [2:0] SEL_COND = 3'b001;
   localparam logic [2:0] SEL_JMP  = 3'b010;
   localparam logic [2:0] SEL_FTCH = 3'b110;
   localparam logic [2:0] SEL_MAP  = 3'b111;

   logic [2:0] nsel;
   logic [2:0] cond;
   logic [9:0] target;
   logic [9:0] uaddr_inc;

   logic       map_hit;
   logic       map_has_wide;
   logic [9:0] map_norm;
   logic [9:0] map_wide;

   logic [9:0] uaddr_nxt;
   logic       wide_nxt;
   logic       disp_nxt;
   logic       illegal_nxt;
   logic       cond_true;

   assign nsel      = uword[15:13];
   assign cond      = uword[12:10];
   assign target    = uword[9:0];
   assign uaddr_inc = uaddr + 10'd1;   // natural 10-bit wrap 1023 -> 0

   // Opcode dispatch table; only four opcodes carry a WIDE variant.
   always_comb begin
      map_hit      = 1'b1;
      map_has_wide = 1'b0;
      map_norm     = FETCH_ADDR;
      map_wide     = FETCH_ADDR;
      case (opcode)
         8'h60: map_norm = 10'd4;
         8'h64: map_norm = 10'd13;
         8'h7E: map_norm = 10'd22;
         8'hB0: map_norm = 10'd31;
         8'hA7: map_norm = 10'd40;
         8'h99: map_norm = 10'd44;
         8'h9B: map_norm = 10'd51;
         8'h9F: map_norm = 10'd58;
         8'h00: map_norm = 10'd68;
         8'h57: map_norm = 10'd69;
         8'h59: map_norm = 10'd70;
         8'h5F: map_norm = 10'd141;
         8'hC4: map_norm = 10'd152;
         8'h13: map_norm = 10'd153;
         8'hB6: map_norm = 10'd181;
         8'hAC: map_norm = 10'd218;
         8'h15: begin map_norm = 10'd86;  map_wide = 10'd75;  map_has_wide = 1'b1; end
         8'h36: begin map_norm = 10'd108; map_wide = 10'd97;  map_has_wide = 1'b1; end
         8'h10: begin map_norm = 10'd130; map_wide = 10'd119; map_has_wide = 1'b1; end
         8'h84: begin map_norm = 10'd165; map_wide = 10'd240; map_has_wide = 1'b1; end
         default: map_hit = 1'b0;
      endcase
   end

   // Flags are only looked at under a conditional select, so X elsewhere is harmless.
   always_comb begin
      cond_true = 1'b0;
      if (nsel == SEL_COND) begin
         case (cond)
            3'b000:  cond_true = z_flag;
            3'b001:  cond_true = n_flag;
            3'b010:  cond_true = 1'b1;
            default: cond_true = 1'b0;
         endcase
      end
   end

   always_comb begin
      uaddr_nxt   = uaddr_inc;
      wide_nxt    = wide_active;
      disp_nxt    = 1'b0;
      illegal_nxt = illegal;
      case (nsel)
         SEL_COND: uaddr_nxt = cond_true ? target : uaddr_inc;
         SEL_JMP:  uaddr_nxt = target;
         SEL_FTCH: begin
            uaddr_nxt = FETCH_ADDR;
            if (cond == 3'b111) wide_nxt = 1'b1;
         end
         SEL_MAP: begin
            disp_nxt = 1'b1;
            wide_nxt = 1'b0;
            if (!map_hit) begin
               uaddr_nxt   = FETCH_ADDR;
               illegal_nxt = 1'b1;
            end else if (wide_active && map_has_wide) begin
               uaddr_nxt = map_wide;
            end else begin
               uaddr_nxt = map_norm;
            end
         end
         default: uaddr_nxt = uaddr_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         uaddr       <= FETCH_ADDR;
         wide_active <= 1'b0;
         dispatch    <= 1'b0;
         illegal     <= 1'b0;
      end else if (stall) begin
         dispatch <= 1'b0;
      end else begin
         uaddr       <= uaddr_nxt;
         wide_active <= wide_nxt;
         dispatch    <= disp_nxt;
         illegal     <= illegal_nxt;
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomized + directed bench for micro_sequencer against a table-driven reference model.
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [25:0] uword;
   logic [7:0]  opcode;
   logic        z_flag, n_flag, stall;
   logic [9:0]  uaddr;
   logic        wide_active, dispatch, illegal;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int m_uaddr;
   bit m_wide, m_disp, m_ill;
   int map_n[int];
   int map_w[int];
   int op_list[$];

   micro_sequencer #(.FETCH_ADDR(10'd0)) dut (
      .clk(clk), .reset(reset), .uword(uword), .opcode(opcode),
      .z_flag(z_flag), .n_flag(n_flag), .stall(stall),
      .uaddr(uaddr), .wide_active(wide_active), .dispatch(dispatch), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [25:0] mw(input int sel, input int cnd, input int tgt);
      logic [9:0] src_alu;
      src_alu = 10'($urandom);
      return {src_alu, 3'(sel), 3'(cnd), 10'(tgt)};
   endfunction

   // Reference: next state from the rules, computed with plain integers and lookup tables.
   task automatic model(input logic [25:0] w, input int op, input bit z, input bit n,
                        input bit st, input bit rst);
      int sel, cnd, tgt;
      sel = int'(w[15:13]); cnd = int'(w[12:10]); tgt = int'(w[9:0]);
      if (rst) begin
         m_uaddr = 0; m_wide = 0; m_disp = 0; m_ill = 0;
      end else if (st) begin
         m_disp = 0;
      end else begin
         m_disp = 0;
         if (sel == 1) begin
            bit t;
            t = (cnd == 0) ? z : (cnd == 1) ? n : (cnd == 2);
            m_uaddr = t ? tgt : (m_uaddr + 1) % 1024;
         end else if (sel == 2) m_uaddr = tgt;
         else if (sel == 6) begin
            m_uaddr = 0;
            if (cnd == 7) m_wide = 1;
         end else if (sel == 7) begin
            m_disp = 1;
            if (!map_n.exists(op)) begin m_uaddr = 0; m_ill = 1; end
            else if (m_wide && map_w.exists(op)) m_uaddr = map_w[op];
            else m_uaddr = map_n[op];
            m_wide = 0;
         end else m_uaddr = (m_uaddr + 1) % 1024;
      end
   endtask

   task automatic step(input string tag, input logic [25:0] w, input int op,
                       input bit z = 0, input bit n = 0, input bit st = 0, input bit rst = 0);
      uword = w; opcode = 8'(op); z_flag = z; n_flag = n; stall = st; reset = rst;
      @(posedge clk);
      model(w, op, z, n, st, rst);
      #1;
      check({tag, ".uaddr"}, 32'(uaddr), 32'(m_uaddr));
      check({tag, ".wide"},  32'(wide_active), 32'(m_wide));
      check({tag, ".disp"},  32'(dispatch), 32'(m_disp));
      check({tag, ".ill"},   32'(illegal), 32'(m_ill));
   endtask

   initial begin
      map_n[8'h60] = 4;   map_n[8'h64] = 13;  map_n[8'h7E] = 22;  map_n[8'hB0] = 31;
      map_n[8'hA7] = 40;  map_n[8'h99] = 44;  map_n[8'h9B] = 51;  map_n[8'h9F] = 58;
      map_n[8'h00] = 68;  map_n[8'h57] = 69;  map_n[8'h59] = 70;  map_n[8'h5F] = 141;
      map_n[8'hC4] = 152; map_n[8'h13] = 153; map_n[8'hB6] = 181; map_n[8'hAC] = 218;
      map_n[8'h15] = 86;  map_w[8'h15] = 75;  map_n[8'h36] = 108; map_w[8'h36] = 97;
      map_n[8'h10] = 130; map_w[8'h10] = 119; map_n[8'h84] = 165; map_w[8'h84] = 240;
      foreach (map_n[k]) op_list.push_back(k);

      m_uaddr = 0; m_wide = 0; m_disp = 0; m_ill = 0;
      reset = 1; stall = 1; uword = '0; opcode = '0; z_flag = 0; n_flag = 0;

      // reset (with stall high) then fetch sequence into dispatch of 0x60
      step("rst", mw(7, 0, 0), 8'hFF, 0, 0, 1, 1);
      check("rst.uaddr0", 32'(uaddr), 32'd0);
      step("seq0", mw(0, 0, 0), 0);
      step("seq1", mw(0, 0, 0), 0);
      step("seq2", mw(0, 0, 0), 0);
      check("seq.uaddr3", 32'(uaddr), 32'd3);
      step("seq3", mw(7, 0, 0), 8'h60);
      check("seq.uaddr4", 32'(uaddr), 32'd4);
      check("seq.disp4", 32'(dispatch), 32'd1);
      step("seq4", mw(0, 0, 0), 0);
      check("seq.disp_off", 32'(dispatch), 32'd0);

      // conditional branches from uaddr 10
      for (int c = 0; c < 2; c++)
         for (int f = 0; f < 2; f++) begin
            step("goto10", mw(2, 0, 10), 0);
            step("cond", mw(1, c, 10'h100), 0, (c == 0) ? bit'(f) : bit'(!f), (c == 1) ? bit'(f) : bit'(!f));
            check("cond.addr", 32'(uaddr), f ? 32'd256 : 32'd11);
         end

      // WIDE prefix then wide/normal dispatch, then WIDE into opcode lacking a wide entry
      step("goto152", mw(2, 0, 152), 0);
      step("wide", mw(6, 7, 0), 0);
      check("wide.set", 32'(wide_active), 32'd1);
      step("wdisp", mw(7, 0, 0), 8'h15);
      check("wdisp.addr", 32'(uaddr), 32'd75);
      step("ndisp", mw(7, 0, 0), 8'h15);
      check("ndisp.addr", 32'(uaddr), 32'd86);
      step("wide2", mw(6, 7, 0), 0);
      step("wdisp60", mw(7, 0, 0), 8'h60);
      check("wdisp60.addr", 32'(uaddr), 32'd4);

      // illegal opcode is sticky
      step("illop", mw(7, 0, 0), 8'hFF);
      check("ill.set", 32'(illegal), 32'd1);
      step("illnorm", mw(7, 0, 0), 8'h64);
      check("ill.sticky", 32'(illegal), 32'd1);

      // stall at 50
      step("goto50", mw(2, 0, 50), 0);
      for (int i = 0; i < 3; i++) step("stall", mw(7, 2, 300), 8'hFF, 1, 1, 1);
      check("stall.hold", 32'(uaddr), 32'd50);
      step("unstall", mw(0, 0, 0), 0);
      check("unstall.addr", 32'(uaddr), 32'd51);

      // wrap and mid-routine reset clearing WIDE
      step("goto1023", mw(2, 0, 1023), 0);
      step("wrap", mw(0, 0, 0), 0);
      check("wrap.addr", 32'(uaddr), 32'd0);
      step("goto190", mw(2, 0, 190), 0);
      step("wide3", mw(6, 7, 0), 0);
      step("midrst", mw(2, 0, 190), 0, 0, 0, 0, 1);
      check("midrst.ill", 32'(illegal), 32'd0);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         int sel, op, r;
         r = int'($urandom_range(0, 99));
         sel = int'($urandom_range(0, 7));
         if (r < 60) op = op_list[$urandom_range(0, op_list.size() - 1)];
         else op = int'($urandom_range(0, 255));
         step("rnd", mw(sel, int'($urandom_range(0, 7)), int'($urandom_range(0, 1023))), op,
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
